// File: rtl/state_pkg.sv
// -----------------------------------------------------------------------------
// state_pkg
//   Shared types for the player controller.
//   State     : walk-animation state driven onto the sprite renderer.
//   JumpPhase : vertical jump FSM phase (GROUND -> RISE -> FALL -> GROUND).
//   POS_W     : width of the sprite position outputs.
//   Helpers   : classify a State as left- or right-facing walk.
// -----------------------------------------------------------------------------
package state_pkg;

  localparam int POS_W = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RIGHT1 = 3'd1,
    RIGHT2 = 3'd2,
    LEFT1  = 3'd3,
    LEFT2  = 3'd4
  } State;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } JumpPhase;

  function automatic logic is_right_state(input State s);
    return (s == RIGHT1) || (s == RIGHT2);
  endfunction

  function automatic logic is_left_state(input State s);
    return (s == LEFT1) || (s == LEFT2);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//   Two-flop synchronizer bringing an asynchronous button into the clk domain.
//   Ports:
//     clk : clock
//     rst : asynchronous active-low reset (clears both flops)
//     d   : asynchronous input
//     q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/player_ctl_1.sv
// -----------------------------------------------------------------------------
// player_ctl_1
//   Frame-rate player controller: horizontal walk with clamping and a two-phase
//   walk animation, plus a vertical jump arc. Everything advances once per frame
//   on the rising edge of vsync; outputs are held between frames.
//
//   Ports:
//     clk          : single clock
//     rst          : asynchronous active-low reset
//     vsync        : VGA vsync (clk domain); rising edge is the frame tick
//     btn_left     : asynchronous walk-left button, active high
//     btn_right    : asynchronous walk-right button, active high
//     btn_jump     : asynchronous jump button, active high
//     xpos_player1 : sprite x offset
//     ypos_player1 : sprite y offset (smaller value = higher on screen)
//     state        : walk-animation state (IDLE/RIGHT1/RIGHT2/LEFT1/LEFT2)
//     jump_phase   : jump FSM state, exposed for observation
//
//   Handshake: there is none; vsync is a free-running level from the timing
//   chain and the buttons are plain levels, so no valid/ready pairs exist.
// -----------------------------------------------------------------------------
module player_ctl_1
  import state_pkg::*;
#(
  parameter int X_START     = 380,
  parameter int X_MAX       = 760,
  parameter int X_STEP      = 4,
  parameter int Y_GROUND    = 100,
  parameter int JUMP_HEIGHT = 64,
  parameter int JUMP_STEP   = 4,
  parameter int ANIM_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [POS_W-1:0] xpos_player1,
  output logic [POS_W-1:0] ypos_player1,
  output State             state,
  output JumpPhase         jump_phase
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  localparam logic [POS_W-1:0] X_START_P   = POS_W'(X_START);
  localparam logic [POS_W-1:0] X_MAX_P     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] X_STEP_P    = POS_W'(X_STEP);
  localparam logic [POS_W-1:0] Y_GROUND_P  = POS_W'(Y_GROUND);
  localparam logic [POS_W-1:0] Y_TOP_P     = POS_W'(Y_GROUND - JUMP_HEIGHT);
  localparam logic [POS_W-1:0] JUMP_STEP_P = POS_W'(JUMP_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ANIM_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Button synchronizers
  // ---------------------------------------------------------------------------
  logic left_s;
  logic right_s;
  logic jump_s;

  btn_sync u_sync_left  (.clk(clk), .rst(rst), .d(btn_left),  .q(left_s));
  btn_sync u_sync_right (.clk(clk), .rst(rst), .d(btn_right), .q(right_s));
  btn_sync u_sync_jump  (.clk(clk), .rst(rst), .d(btn_jump),  .q(jump_s));

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             vsync_q;
  logic             armed_q;      // low only for the first cycle after reset
  logic             jump_prev_q;  // synchronized jump as seen at the last tick
  logic [POS_W-1:0] xpos_q,  xpos_d;
  logic [POS_W-1:0] ypos_q,  ypos_d;
  State             state_q, state_d;
  JumpPhase         jump_q,  jump_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             phase_q, phase_d;
  logic             jump_prev_d;

  // The armed flag blocks a tick on the very first cycle after reset release:
  // vsync_q was forced low by reset, so a vsync that was already high would
  // otherwise look like a fresh rising edge.
  logic tick;
  assign tick = vsync & ~vsync_q & armed_q;

  logic walk_r;
  logic walk_l;
  assign walk_r = right_s & ~left_s;
  assign walk_l = left_s & ~right_s;

  // ---------------------------------------------------------------------------
  // Next-state logic (horizontal, animation and jump FSM)
  // ---------------------------------------------------------------------------
  logic             reversal;
  logic [CNT_W-1:0] eff_cnt;
  logic             eff_phase;
  logic [POS_W:0]   x_sum;
  logic [POS_W:0]   y_sum;

  always_comb begin
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    state_d     = state_q;
    jump_d      = jump_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    jump_prev_d = jump_prev_q;
    reversal    = 1'b0;
    eff_cnt     = cnt_q;
    eff_phase   = phase_q;
    // One spare bit so that the right clamp and landing tests cannot wrap.
    x_sum       = {1'b0, xpos_q} + {1'b0, X_STEP_P};
    y_sum       = {1'b0, ypos_q} + {1'b0, JUMP_STEP_P};

    if (tick) begin
      jump_prev_d = jump_s;

      // ---- walk and animation ----
      if (walk_r || walk_l) begin
        // A reversal restarts the animation exactly as if walking from IDLE.
        reversal  = walk_r ? is_left_state(state_q) : is_right_state(state_q);
        eff_cnt   = reversal ? '0   : cnt_q;
        eff_phase = reversal ? 1'b0 : phase_q;

        // The displayed phase is the one in force before this tick's advance,
        // so the first ANIM_FRAMES walking ticks all show phase 0.
        if (walk_r) state_d = eff_phase ? RIGHT2 : RIGHT1;
        else        state_d = eff_phase ? LEFT2  : LEFT1;

        if (eff_cnt == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~eff_phase;
        end else begin
          cnt_d   = eff_cnt + 1'b1;
          phase_d = eff_phase;
        end

        if (walk_r) begin
          xpos_d = (x_sum >= {1'b0, X_MAX_P}) ? X_MAX_P : x_sum[POS_W-1:0];
        end else begin
          xpos_d = (xpos_q < X_STEP_P) ? '0 : xpos_q - X_STEP_P;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
      end

      // ---- jump FSM ----
      unique case (jump_q)
        GROUND: begin
          // Launch tick only changes phase; the first rise step is next tick.
          if (jump_s && !jump_prev_q) jump_d = RISE;
        end
        RISE: begin
          if (ypos_q <= Y_TOP_P + JUMP_STEP_P) begin
            ypos_d = Y_TOP_P;
            jump_d = FALL;
          end else begin
            ypos_d = ypos_q - JUMP_STEP_P;
          end
        end
        FALL: begin
          if (y_sum >= {1'b0, Y_GROUND_P}) begin
            ypos_d = Y_GROUND_P;
            jump_d = GROUND;
          end else begin
            ypos_d = y_sum[POS_W-1:0];
          end
        end
        default: begin
          jump_d = GROUND;
          ypos_d = Y_GROUND_P;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      armed_q     <= 1'b0;
      jump_prev_q <= 1'b0;
      xpos_q      <= X_START_P;
      ypos_q      <= Y_GROUND_P;
      state_q     <= IDLE;
      jump_q      <= GROUND;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      armed_q     <= 1'b1;
      jump_prev_q <= jump_prev_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      state_q     <= state_d;
      jump_q      <= jump_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign xpos_player1 = xpos_q;
  assign ypos_player1 = ypos_q;
  assign state        = state_q;
  assign jump_phase   = jump_q;

endmodule

// File: tb/tb_player_ctl_1.sv
// -----------------------------------------------------------------------------
// tb_player_ctl_1
//   Self-checking bench for player_ctl_1 with default parameters. A frame-level
//   reference model (walk run length, jump arc index) predicts outputs after
//   every vsync tick; directed scenarios cover clamps, animation timing,
//   jump arc, held jump across landing, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_player_ctl_1;
  import state_pkg::*;

  localparam int X_START  = 380;
  localparam int X_MAX    = 760;
  localparam int X_STEP   = 4;
  localparam int Y_GROUND = 100;
  localparam int JUMP_H   = 64;
  localparam int J_STEP   = 4;
  localparam int ANIM     = 8;
  localparam int RISE_N   = JUMP_H / J_STEP;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [11:0] xpos_player1;
  logic [11:0] ypos_player1;
  State       state;
  JumpPhase   jump_phase;

  always #5 clk = ~clk;

  player_ctl_1 dut (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .xpos_player1 (xpos_player1),
    .ypos_player1 (ypos_player1),
    .state        (state),
    .jump_phase   (jump_phase)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", tag, frame_no, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: x position, length of the current same-direction walk
  // run, walk direction (0 none, 1 right, 2 left), ticks since jump launch
  // (-1 on the ground) and the jump button value at the previous tick.
  int m_x, m_y, m_run, m_dir, m_arc, m_jprev;
  State     m_state;
  JumpPhase m_jph;

  function automatic void m_reset();
    m_x = X_START; m_y = Y_GROUND; m_run = 0; m_dir = 0;
    m_arc = -1; m_jprev = 0; m_state = IDLE; m_jph = GROUND;
  endfunction

  function automatic void m_step(input logic l, input logic r, input logic j);
    int w;
    w = (l ^ r) ? (r ? 1 : 2) : 0;
    if (w == 0) begin
      m_run = 0;
      m_state = IDLE;
    end else begin
      m_run = (w == m_dir) ? m_run + 1 : 1;
      if (w == 1) begin
        m_state = (((m_run - 1) / ANIM) % 2 == 0) ? RIGHT1 : RIGHT2;
        m_x = (m_x + X_STEP > X_MAX) ? X_MAX : m_x + X_STEP;
      end else begin
        m_state = (((m_run - 1) / ANIM) % 2 == 0) ? LEFT1 : LEFT2;
        m_x = (m_x < X_STEP) ? 0 : m_x - X_STEP;
      end
    end
    m_dir = w;

    if (m_arc < 0) begin
      if (j && !m_jprev) m_arc = 0;
    end else begin
      m_arc++;
    end
    m_jprev = int'(j);

    if (m_arc < 0) begin
      m_y = Y_GROUND; m_jph = GROUND;
    end else if (m_arc <= RISE_N) begin
      m_y = Y_GROUND - J_STEP * m_arc;
      m_jph = (m_arc < RISE_N) ? RISE : FALL;
    end else begin
      m_y = Y_GROUND - JUMP_H + J_STEP * (m_arc - RISE_N);
      m_jph = FALL;
      if (m_arc == 2 * RISE_N) begin
        m_arc = -1;
        m_jph = GROUND;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // One frame: set buttons, let them settle through the synchronizer while
  // vsync is low (outputs must hold), then a vsync pulse produces one tick.
  task automatic frame(input logic l, input logic r, input logic j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (3) @(negedge clk);
    check("hold_x", 32'(xpos_player1), 32'(m_x));
    check("hold_state", 32'(state), 32'(m_state));
    vsync = 1'b1;
    @(negedge clk);
    frame_no++;
    m_step(l, r, j);
    check("xpos", 32'(xpos_player1), 32'(m_x));
    check("ypos", 32'(ypos_player1), 32'(m_y));
    check("state", 32'(state), 32'(m_state));
    check("jump_phase", 32'(jump_phase), 32'(m_jph));
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    #3 rst = 1'b0;
    #1;
    check("rst_x", 32'(xpos_player1), 32'(X_START));
    check("rst_y", 32'(ypos_player1), 32'(Y_GROUND));
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_jump", 32'(jump_phase), 32'(GROUND));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Right held for 10 ticks: RIGHT1 for 8, RIGHT2 for 2, x 380 -> 420.
    for (int i = 1; i <= 10; i++) begin
      frame(1'b0, 1'b1, 1'b0);
      check("r10_state", 32'(state), (i <= 8) ? 32'(RIGHT1) : 32'(RIGHT2));
    end
    check("r10_x", 32'(xpos_player1), 32'd420);

    // Both held: no walk, IDLE, x unchanged.
    frame(1'b1, 1'b1, 1'b0);
    check("both_x", 32'(xpos_player1), 32'd420);
    check("both_state", 32'(state), 32'(IDLE));

    // Reversal mid-run restarts at phase 0.
    for (int i = 0; i < 9; i++) frame(1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    check("rev_state", 32'(state), 32'(LEFT1));

    // Walk left down to x=4, pause one tick, then three more left ticks.
    do_reset();
    for (int i = 0; i < (X_START - 4) / X_STEP; i++) frame(1'b1, 1'b0, 1'b0);
    check("left_x4", 32'(xpos_player1), 32'd4);
    frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 1'b0, 1'b0);
      check("lclamp_x", 32'(xpos_player1), 32'd0);
      check("lclamp_state", 32'(state), 32'(LEFT1));
    end

    // Right clamp at X_MAX.
    for (int i = 0; i < X_MAX / X_STEP + 3; i++) frame(1'b0, 1'b1, 1'b0);
    check("rclamp_x", 32'(xpos_player1), 32'(X_MAX));

    // Single jump pulse with a second press mid-arc, full arc to landing.
    frame(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * RISE_N; i++) begin
      frame(1'b0, 1'b0, (i == 10 || i == 20) ? 1'b1 : 1'b0);
      if (i == RISE_N - 1) check("apex_y", 32'(ypos_player1), 32'(Y_GROUND - JUMP_H));
    end
    check("land_y", 32'(ypos_player1), 32'(Y_GROUND));
    check("land_phase", 32'(jump_phase), 32'(GROUND));

    // Jump held through landing: no relaunch until released and re-pressed.
    for (int i = 0; i < 2 * RISE_N + 6; i++) frame(1'b0, 1'b0, 1'b1);
    check("held_phase", 32'(jump_phase), 32'(GROUND));
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    check("repress_phase", 32'(jump_phase), 32'(RISE));

    // Randomized walk/jump mix.
    for (int i = 0; i < 300; i++) begin
      logic l, r, j;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) != 0) && !($urandom_range(0, 3) == 0 && l);
      j = ($urandom_range(0, 5) == 0);
      frame(l, r, j);
    end

    // Reset asserted mid-jump at ypos 60 while walking: immediate, no clk edge.
    do_reset();
    frame(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && m_y != 60; i++) frame(1'b0, 1'b1, 1'b0);
    check("pre_rst_y", 32'(ypos_player1), 32'd60);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_x", 32'(xpos_player1), 32'(X_START));
    check("async_rst_y", 32'(ypos_player1), 32'(Y_GROUND));
    check("async_rst_state", 32'(state), 32'(IDLE));
    check("async_rst_jump", 32'(jump_phase), 32'(GROUND));
    m_reset();

    // vsync already high at reset release: no tick until it falls and rises.
    @(negedge clk);
    vsync = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("no_tick_x", 32'(xpos_player1), 32'(X_START));
    check("no_tick_state", 32'(state), 32'(IDLE));
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    m_step(1'b0, 1'b1, 1'b0);
    check("post_rel_x", 32'(xpos_player1), 32'(m_x));
    check("post_rel_state", 32'(state), 32'(m_state));
    vsync = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/player_ctl_1.md
PLAYER_CTL_1 -- requirements
Module: player_ctl_1

Interface
REQ-001 SHALL have parameter X_START, default 380, reset x position.
REQ-002 SHALL have parameter X_MAX, default 760, right clamp (screen 800 minus sprite width 40); left clamp fixed at 0.
REQ-003 SHALL have parameter X_STEP, default 4, pixels moved per frame while walking.
REQ-004 SHALL have parameter Y_GROUND, default 100, ypos at rest.
REQ-005 SHALL have parameter JUMP_HEIGHT, default 64, peak rise above Y_GROUND.
REQ-006 SHALL have parameter JUMP_STEP, default 4, vertical pixels per frame during a jump.
REQ-007 SHALL have parameter ANIM_FRAMES, default 8, frames per walk-animation phase.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is in this one clock domain.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-010 SHALL have port vsync, input, 1 bit: VGA vsync from the timing chain in the clk domain; its rising edge is the frame tick.
REQ-011 SHALL have ports btn_left, btn_right, btn_jump, input, 1 bit each: asynchronous active-high buttons.
REQ-012 SHALL have port xpos_player1, output, 12 bits: sprite x offset.
REQ-013 SHALL have port ypos_player1, output, 12 bits: sprite y offset; a smaller value places the sprite higher.
REQ-014 SHALL have port state, output, type State: IDLE, RIGHT1, RIGHT2, LEFT1, LEFT2.

Function
REQ-015 SHALL pass each button through a 2-FF synchronizer before use.
REQ-016 SHALL detect the frame tick as vsync=1 with the registered previous vsync=0; one tick per frame.
REQ-017 SHALL change all outputs only on the clk edge after the cycle in which the tick is detected, and hold them constant otherwise.
REQ-018 SHALL treat left alone as walk-left, right alone as walk-right, and both or neither as no walk.
REQ-019 SHALL, on walk-right, set xpos = min(xpos+X_STEP, X_MAX); on walk-left, set xpos = max(xpos-X_STEP, 0), computed without 12-bit underflow.
REQ-020 SHALL keep a walk-animation frame counter and phase bit: the counter increments each walking tick; when it reaches ANIM_FRAMES-1 it wraps to 0 and toggles the phase.
REQ-021 SHALL output state = RIGHT1/RIGHT2 (phase 0/1) on walk-right and LEFT1/LEFT2 on walk-left; a clamped walk still animates.
REQ-022 SHALL, on a tick with no walk, output state = IDLE and clear the counter and phase.
REQ-023 SHALL, on a direction reversal, restart the animation at phase 0 with counter 0.
REQ-024 SHALL implement the jump FSM GROUND -> RISE -> FALL -> GROUND, advancing only on ticks.
REQ-025 SHALL, in GROUND, enter RISE on a tick where the synchronized jump is 1 and was 0 at the previous tick (rising edge at frame rate).
REQ-026 SHALL, in RISE, decrement ypos by JUMP_STEP each tick, clamp at Y_GROUND-JUMP_HEIGHT, and enter FALL when that value is reached.
REQ-027 SHALL, in FALL, increment ypos by JUMP_STEP each tick, clamp at Y_GROUND, and enter GROUND when that value is reached.
REQ-028 SHALL ignore jump presses during RISE and FALL, and SHALL NOT cut the arc short when jump is released.
REQ-029 SHALL require a jump held through landing to be released and re-pressed before another jump.
REQ-030 SHALL allow horizontal walking and animation during RISE and FALL, independent of the jump FSM.

Reset
REQ-031 SHALL, on rst low, immediately set xpos=X_START, ypos=Y_GROUND, state=IDLE, jump FSM=GROUND, counter/phase=0, synchronizers, previous-vsync and previous-jump registers=0, including mid-jump or mid-walk.
REQ-032 SHALL detect no tick on the first vsync-high cycle after reset release unless vsync was low in the prior cycle.

Structure
REQ-033 SHALL use the existing State typedef from state_pkg; a JumpPhase enum (GROUND, RISE, FALL) SHALL be added to state_pkg.
REQ-034 SHALL place the synchronizer in a sub-module btn_sync, instantiated once per button; the rest stays in player_ctl_1.

Verification
REQ-035 Reset then right held for 10 ticks -> xpos 380->420; state RIGHT1 for ticks 1-8, RIGHT2 for ticks 9-10.
REQ-036 xpos=4, left held for 3 ticks -> xpos 0, 0, 0; state LEFT1 on every tick.
REQ-037 Jump pulsed at one tick from ground -> ypos 96, 92 ... 36 over 16 ticks, then 40 ... 100 over 16 ticks, then GROUND; a second press mid-arc has no effect.
REQ-038 Left and right both held -> xpos unchanged, state IDLE, counter 0.
REQ-039 rst asserted mid-jump at ypos=60 -> immediately xpos=380, ypos=100, state IDLE with no clk edge.
REQ-040 Jump held continuously across landing -> no second jump until jump is released for at least one tick and then pressed.
